// File: rtl/uc_pkg.sv
// -----------------------------------------------------------------------------
// uc_pkg
// Shared definitions for the multicycle control unit: RV32-style opcode
// constants, the sequencer state encoding, datapath source-select and
// branch-flag-select codes, and the control bundle that the decoder produces
// and the sequencer holds for the duration of one instruction.
// -----------------------------------------------------------------------------
package uc_pkg;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // Datapath source select (OP_MEM_I)
  localparam logic [1:0] OMI_RS1_RS2 = 2'b00;  // rs1 +/- rs2
  localparam logic [1:0] OMI_RS1_IMM = 2'b01;  // rs1 + imm
  localparam logic [1:0] OMI_LOAD    = 2'b10;  // load data
  localparam logic [1:0] OMI_STORE   = 2'b11;  // store address

  // Branch flag mux select codes
  localparam logic [2:0] FLAG_SEL_EQ   = 3'd0;
  localparam logic [2:0] FLAG_SEL_NE   = 3'd1;
  localparam logic [2:0] FLAG_SEL_LT   = 3'd2;
  localparam logic [2:0] FLAG_SEL_GE   = 3'd3;
  localparam logic [2:0] FLAG_SEL_LTU  = 3'd4;
  localparam logic [2:0] FLAG_SEL_GEU  = 3'd5;
  localparam logic [2:0] FLAG_SEL_NONE = 3'b111;  // flag mux returns 0

  // Select bundle held stable from DECODE through WB
  typedef struct packed {
    logic [1:0] op_mem_i;
    logic       add_sub;
    logic       jal;
    logic       jalr;
    logic       auipc;
    logic [2:0] select_flags;
  } ctrl_t;

  // Quiescent bundle: add, no jump, no branch
  localparam ctrl_t CTRL_IDLE = '{
    op_mem_i:     OMI_RS1_RS2,
    add_sub:      1'b0,
    jal:          1'b0,
    jalr:         1'b0,
    auipc:        1'b0,
    select_flags: FLAG_SEL_NONE
  };

  // Branch funct3 -> {supported, flag select}. 010/011 have no branch form.
  function automatic logic [3:0] branch_flag_sel(input logic [2:0] funct3);
    logic [3:0] res;
    case (funct3)
      3'b000:  res = {1'b1, FLAG_SEL_EQ};
      3'b001:  res = {1'b1, FLAG_SEL_NE};
      3'b100:  res = {1'b1, FLAG_SEL_LT};
      3'b101:  res = {1'b1, FLAG_SEL_GE};
      3'b110:  res = {1'b1, FLAG_SEL_LTU};
      3'b111:  res = {1'b1, FLAG_SEL_GEU};
      default: res = {1'b0, FLAG_SEL_NONE};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational decode of the registered instruction fields into the
// datapath select bundle plus the sequencing attributes the FSM needs.
//
// Ports:
//   opcode_i     instruction[6:0]
//   funct3_i     instruction[14:12]
//   funct7_5_i   instruction[30]
//   ctrl_o       select bundle (CTRL_IDLE when the instruction is not legal)
//   legal_o      instruction is supported by this control unit
//   is_mem_o     load or store: sequence goes through MEM
//   is_store_o   store: WE_mem in MEM, no register writeback
//   writes_reg_o register file is written in WB
// -----------------------------------------------------------------------------
module instr_decoder
  import uc_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output ctrl_t      ctrl_o,
  output logic       legal_o,
  output logic       is_mem_o,
  output logic       is_store_o,
  output logic       writes_reg_o
);

  logic [3:0] br_sel;

  always_comb begin
    ctrl_o       = CTRL_IDLE;
    legal_o      = 1'b0;
    is_mem_o     = 1'b0;
    is_store_o   = 1'b0;
    writes_reg_o = 1'b0;
    br_sel       = branch_flag_sel(funct3_i);

    case (opcode_i)
      OPC_R: begin
        // Only ADD/SUB are implemented
        if (funct3_i == 3'b000) begin
          legal_o         = 1'b1;
          writes_reg_o    = 1'b1;
          ctrl_o.op_mem_i = OMI_RS1_RS2;
          ctrl_o.add_sub  = funct7_5_i;
        end
      end
      OPC_IALU: begin
        // Only ADDI is implemented
        if (funct3_i == 3'b000) begin
          legal_o         = 1'b1;
          writes_reg_o    = 1'b1;
          ctrl_o.op_mem_i = OMI_RS1_IMM;
        end
      end
      OPC_LOAD: begin
        legal_o         = 1'b1;
        is_mem_o        = 1'b1;
        writes_reg_o    = 1'b1;
        ctrl_o.op_mem_i = OMI_LOAD;
      end
      OPC_STORE: begin
        legal_o         = 1'b1;
        is_mem_o        = 1'b1;
        is_store_o      = 1'b1;
        ctrl_o.op_mem_i = OMI_STORE;
      end
      OPC_BRANCH: begin
        // Compare is done as rs1 - rs2; the flag mux picks the condition
        if (br_sel[3]) begin
          legal_o             = 1'b1;
          ctrl_o.op_mem_i     = OMI_RS1_RS2;
          ctrl_o.add_sub      = 1'b1;
          ctrl_o.select_flags = br_sel[2:0];
        end
      end
      OPC_JAL: begin
        legal_o      = 1'b1;
        writes_reg_o = 1'b1;
        ctrl_o.jal   = 1'b1;
      end
      OPC_JALR: begin
        legal_o      = 1'b1;
        writes_reg_o = 1'b1;
        ctrl_o.jalr  = 1'b1;
      end
      OPC_AUIPC: begin
        legal_o      = 1'b1;
        writes_reg_o = 1'b1;
        ctrl_o.auipc = 1'b1;
      end
      // SYSTEM, LUI and everything else stop the machine
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Sequences one instruction at a time through FETCH/DECODE/EXEC/[MEM]/WB and
// drives every strobe and select of the fetch/decode/execute datapath.
// Selects come straight from the decoder during DECODE and from the latched
// bundle in EXEC..WB, so they are stable from DECODE to the end of WB.
//
// Ports:
//   clk          rising-edge clock (datapath IR loads on the falling edge)
//   reset        asynchronous, active-low reset
//   start        level; leaves IDLE when high
//   stall        freezes the FSM and masks all strobes (ignored in IDLE/HALT)
//   opcode       IR[6:0]
//   funct3       IR[14:12]
//   funct7_5     IR[30]
//   IR_load      instruction register load strobe (FETCH)
//   PC_load      program counter load strobe (WB)
//   WE_reg       register file write strobe (WB)
//   WE_mem       data memory write strobe (MEM of a store)
//   OP_MEM_I     datapath source select
//   ADD_SUB      0 add, 1 subtract
//   JAL/JALR     jump selects
//   AUIPC        PC+imm writeback select
//   select_flags branch flag mux select (FLAG_SEL_NONE = no branch)
//   busy         FSM is in FETCH..WB
//   halted       sticky, machine is in HALT
//   illegal      sticky, halt was caused by an unsupported instruction
//   instret      retired instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_control_unit
  import uc_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  output logic                 IR_load,
  output logic                 PC_load,
  output logic                 WE_reg,
  output logic                 WE_mem,
  output logic [1:0]           OP_MEM_I,
  output logic                 ADD_SUB,
  output logic                 JAL,
  output logic                 JALR,
  output logic                 AUIPC,
  output logic [2:0]           select_flags,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_e state_q, state_d;

  ctrl_t dec_ctrl;
  logic  dec_legal, dec_is_mem, dec_is_store, dec_writes_reg;

  ctrl_t ctrl_q, ctrl_d;
  logic  is_mem_q, is_mem_d;
  logic  is_store_q, is_store_d;
  logic  writes_reg_q, writes_reg_d;
  logic  halted_q, halted_d;
  logic  illegal_q, illegal_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  ctrl_t sel;
  logic  decode_done;
  logic  retire;

  instr_decoder u_dec (
    .opcode_i     (opcode),
    .funct3_i     (funct3),
    .funct7_5_i   (funct7_5),
    .ctrl_o       (dec_ctrl),
    .legal_o      (dec_legal),
    .is_mem_o     (dec_is_mem),
    .is_store_o   (dec_is_store),
    .writes_reg_o (dec_writes_reg)
  );

  // DECODE completes on the first unstalled cycle; WB likewise retires
  assign decode_done = (state_q == ST_DECODE) && !stall;
  assign retire      = (state_q == ST_WB) && !stall;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (!stall) state_d = ST_DECODE;
      ST_DECODE: if (!stall) state_d = dec_legal ? ST_EXEC : ST_HALT;
      ST_EXEC:   if (!stall) state_d = is_mem_q ? ST_MEM : ST_WB;
      ST_MEM:    if (!stall) state_d = ST_WB;
      ST_WB:     if (!stall) state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;  // only reset leaves HALT
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Strobes are masked by stall so a held strobe fires exactly
  // once, on the cycle stall drops.
  // ---------------------------------------------------------------------------
  always_comb begin
    IR_load = 1'b0;
    PC_load = 1'b0;
    WE_reg  = 1'b0;
    WE_mem  = 1'b0;
    sel     = CTRL_IDLE;
    case (state_q)
      ST_FETCH:  IR_load = !stall;
      ST_DECODE: sel = dec_ctrl;
      ST_EXEC:   sel = ctrl_q;
      ST_MEM: begin
        sel    = ctrl_q;
        WE_mem = is_store_q && !stall;
      end
      ST_WB: begin
        sel     = ctrl_q;
        PC_load = !stall;
        WE_reg  = writes_reg_q && !stall;
      end
      default: ;
    endcase
  end

  assign OP_MEM_I     = sel.op_mem_i;
  assign ADD_SUB      = sel.add_sub;
  assign JAL          = sel.jal;
  assign JALR         = sel.jalr;
  assign AUIPC        = sel.auipc;
  assign select_flags = sel.select_flags;

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

  // ---------------------------------------------------------------------------
  // Instruction bundle, sticky halt flags and retire counter
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d       = ctrl_q;
    is_mem_d     = is_mem_q;
    is_store_d   = is_store_q;
    writes_reg_d = writes_reg_q;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    instret_d    = instret_q;

    if (decode_done) begin
      ctrl_d       = dec_ctrl;
      is_mem_d     = dec_is_mem;
      is_store_d   = dec_is_store;
      writes_reg_d = dec_writes_reg;
      if (!dec_legal) begin
        // ECALL/EBREAK is a clean stop; anything else is flagged
        halted_d  = 1'b1;
        illegal_d = (opcode != OPC_SYSTEM);
      end
    end

    if (retire) begin
      instret_d = instret_q + INSTRET_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q       <= CTRL_IDLE;
      is_mem_q     <= 1'b0;
      is_store_q   <= 1'b0;
      writes_reg_q <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      instret_q    <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      is_mem_q     <= is_mem_d;
      is_store_q   <= is_store_d;
      writes_reg_q <= writes_reg_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      instret_q    <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, funct7_5;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        IR_load, PC_load, WE_reg, WE_mem;
  logic [1:0]  OP_MEM_I;
  logic        ADD_SUB, JAL, JALR, AUIPC;
  logic [2:0]  select_flags;
  logic        busy, halted, illegal;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_control_unit #(.INSTRET_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .IR_load(IR_load), .PC_load(PC_load), .WE_reg(WE_reg), .WE_mem(WE_mem),
    .OP_MEM_I(OP_MEM_I), .ADD_SUB(ADD_SUB), .JAL(JAL), .JALR(JALR),
    .AUIPC(AUIPC), .select_flags(select_flags), .busy(busy),
    .halted(halted), .illegal(illegal), .instret(instret)
  );

  // One instruction: fields, expected halt outcome, expected selects/sequencing
  typedef struct {
    logic [6:0] opc; logic [2:0] f3; logic f7;
    logic halt; logic ill;
    logic [1:0] omi; logic as; logic jal; logic jalr; logic auipc; logic [2:0] sf;
    logic mem; logic st; logic wr;
  } vec_t;

  // Scoreboard record, checked when PC_load appears
  typedef struct { logic wr; int lat; int prev; } sb_t;

  sb_t  exp_q[$];
  int   checks = 0, errors = 0, cyc = 0, fetch_cyc = 0, n_ret = 0;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Advance one cycle; stall is applied just after the edge, outputs sampled after
  task automatic tick(input logic st);
    sb_t r;
    @(posedge clk);
    #1 stall = st;
    #1 cyc++;
    if (IR_load) fetch_cyc = cyc;
    if (PC_load) begin
      if (exp_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        r = exp_q.pop_front();
        chk("sb_we_reg", WE_reg, r.wr);
        chk("sb_latency", cyc - fetch_cyc + 1, r.lat);
        chk("sb_instret", instret, r.prev);
      end
    end
  endtask

  task automatic reset_state_chk(input string nm);
    chk({nm, "_outs"}, {IR_load, PC_load, WE_reg, WE_mem, OP_MEM_I, ADD_SUB, JAL,
                        JALR, AUIPC, busy, halted, illegal}, 64'd0);
    chk({nm, "_sel_flags"}, select_flags, 3'b111);
    chk({nm, "_instret"}, instret, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; stall = 1'b0;
    #1 reset_state_chk("rst_async");
    repeat (3) begin
      tick(1'b0);
      reset_state_chk("rst_hold");
    end
    reset = 1'b1;
    exp_q.delete();
    n_ret = 0;
  endtask

  task automatic wait_fetch(input string nm, output bit found);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick(1'b0);
      found = IR_load;
    end
    chk({nm, "_fetch"}, found, 1'b1);
  endtask

  task automatic strobes_zero(input string nm);
    chk({nm, "_strobes"}, {IR_load, PC_load, WE_reg, WE_mem}, 4'b0000);
  endtask

  task automatic sels_chk(input string nm, input vec_t v);
    chk({nm, "_sels"}, {OP_MEM_I, ADD_SUB, JAL, JALR, AUIPC, select_flags},
        {v.omi, v.as, v.jal, v.jalr, v.auipc, v.sf});
  endtask

  task automatic push_exp(input logic wr, input int lat);
    sb_t r;
    n_ret++;
    r.wr = wr; r.lat = lat; r.prev = n_ret - 1;
    exp_q.push_back(r);
  endtask

  // Runs one instruction from FETCH through WB (or into HALT)
  task automatic run_vec(input vec_t v, input string nm);
    bit found;
    wait_fetch(nm, found);
    if (!found) return;
    opcode = v.opc; funct3 = v.f3; funct7_5 = v.f7;
    if (!v.halt) push_exp(v.wr, v.mem ? 5 : 4);
    tick(1'b0);                              // DECODE
    strobes_zero({nm, "_dec"});
    if (v.halt) begin
      tick(1'b0);                            // HALT
      chk({nm, "_halted"}, halted, 1'b1);
      chk({nm, "_illegal"}, illegal, v.ill);
      chk({nm, "_halt_busy"}, busy, 1'b0);
      strobes_zero({nm, "_halt"});
      return;
    end
    sels_chk({nm, "_dec"}, v);
    tick(1'b0);                              // EXEC
    sels_chk({nm, "_exec"}, v);
    strobes_zero({nm, "_exec"});
    chk({nm, "_exec_busy"}, busy, 1'b1);
    if (v.mem) begin
      tick(1'b0);                            // MEM
      sels_chk({nm, "_mem"}, v);
      chk({nm, "_mem_we_mem"}, WE_mem, v.st);
      chk({nm, "_mem_other"}, {IR_load, PC_load, WE_reg}, 3'b000);
    end
    tick(1'b0);                              // WB
    sels_chk({nm, "_wb"}, v);
    chk({nm, "_wb_pc_load"}, PC_load, 1'b1);
    chk({nm, "_wb_we_mem"}, WE_mem, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit   found;
    int   pulses;
    vec_t v;

    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    //                opc         f3      f7    halt  ill   omi    as    jal   jalr  auipc sf       mem   st    wr
    tbl[0]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0,   1'b0, 1'b0, 1'b0};
    tbl[5]  = '{7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1,   1'b0, 1'b0, 1'b0};
    tbl[6]  = '{7'b1100011, 3'b100, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2,   1'b0, 1'b0, 1'b0};
    tbl[7]  = '{7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3,   1'b0, 1'b0, 1'b0};
    tbl[8]  = '{7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4,   1'b0, 1'b0, 1'b0};
    tbl[9]  = '{7'b1100011, 3'b111, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5,   1'b0, 1'b0, 1'b0};
    tbl[10] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};

    // Table: back-to-back instructions, ending with an illegal branch
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    chk("table_instret", instret, 32'd14);
    for (int i = 0; i < 4; i++) begin
      start = i[0];
      tick(1'b0);
      chk("halt_hold", {busy, halted, illegal, IR_load, PC_load}, 5'b01100);
    end

    // JALR then ECALL: clean halt, start toggling cannot restart
    do_reset();
    start = 1'b1;
    run_vec(tbl[12], "jalr");
    v = '{7'b1110011, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
    run_vec(v, "ecall");
    chk("ecall_instret", instret, 32'd1);
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      tick(1'b0);
      chk("ecall_hold", {busy, halted, illegal, IR_load}, 4'b0100);
    end

    // Stall held over WB, with start dropped mid-instruction
    do_reset();
    start = 1'b1;
    wait_fetch("stall_r", found);
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
    start = 1'b0;
    push_exp(1'b1, 7);
    tick(1'b0);
    tick(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);                            // WB, stalled
      chk("stall_wb_strobes", {PC_load, WE_reg, busy}, 3'b001);
      chk("stall_wb_sel", ADD_SUB, 1'b1);
    end
    tick(1'b0);
    chk("stall_wb_release", {PC_load, WE_reg}, 2'b11);
    tick(1'b0);
    chk("stall_wb_next_fetch", {IR_load, PC_load}, 2'b10);

    // Stall held over MEM of a store
    opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
    push_exp(1'b0, 8);
    tick(1'b0);
    tick(1'b0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick(i < 3);
      pulses += int'(WE_mem);
      chk("stall_mem_we_mem", WE_mem, i == 3);
    end
    tick(1'b0);
    pulses += int'(WE_mem);
    chk("stall_mem_pulses", pulses, 1);
    chk("stall_mem_wb", {PC_load, WE_reg}, 2'b10);
    chk("stall_instret", instret, 32'd1);

    // Asynchronous reset in EXEC of AUIPC
    do_reset();
    start = 1'b1;
    run_vec(tbl[13], "pre_auipc");
    wait_fetch("auipc", found);
    opcode = 7'b0010111; funct3 = 3'b000; funct7_5 = 1'b0;
    tick(1'b0);
    tick(1'b0);
    chk("auipc_exec", {AUIPC, busy, instret}, {1'b1, 1'b1, 32'd1});
    reset = 1'b0;
    #1 reset_state_chk("rst_mid");
    exp_q.delete();
    n_ret = 0;
    start = 1'b0;
    tick(1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      chk("idle_after_rst", {busy, IR_load, WE_reg, PC_load}, 4'b0000);
    end

    // LUI is unsupported
    start = 1'b1;
    v = '{7'b0110111, 3'b000, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
    run_vec(v, "lui");
    chk("lui_instret", instret, 32'd0);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
